// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: input request channel and result channel.
// slave = the shifter, master = the producer/consumer driving it.
interface shift_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_carry;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_carry
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_carry
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined log barrel shifter (SLL/SRA/SRL/ROR) with zero and carry-out flags.
// One register stage per shift-amount bit; global stall from the output side.
module shift_pipe_stage #(
    parameter int WIDTH = 16,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sign,
    input  logic             cin,
    output logic [WIDTH-1:0] q,
    output logic             cout
);
    localparam int S = 1 << K;

    logic [WIDTH-1:0] sll, srl, sra, ror;

    assign sll = d << S;
    assign srl = d >> S;
    // sign is the original operand MSB, not this stage's MSB
    assign sra = srl | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> S));
    assign ror = srl | (d << (WIDTH - S));

    // Carry keeps the last bit shifted out; a later non-shifting stage leaves it alone.
    always_comb begin
        q    = d;
        cout = cin;
        if (en) begin
            case (mode)
                2'b00: begin q = sll; cout = d[WIDTH-S]; end
                2'b01: begin q = sra; cout = d[S-1];     end
                2'b10: begin q = srl; cout = d[S-1];     end
                default: begin q = ror; cout = ror[WIDTH-1]; end
            endcase
        end
    end
endmodule

module shift_pipe #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    shift_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic                       adv;
    logic [SHW-1:0]             vld_pipe;
    logic [SHW-1:0][WIDTH-1:0]  d_in, d_nx, d_q;
    logic [SHW-1:0][SHW-1:0]    a_in;
    logic [SHW-2:0][SHW-1:0]    a_q;
    logic [SHW-1:0][1:0]        m_in;
    logic [SHW-2:0][1:0]        m_q;
    logic [SHW-1:0]             s_in, c_in, c_nx, c_q;
    logic [SHW-2:0]             s_q;
    logic                       zero_q;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign d_in[k] = bus.in_data;
                assign a_in[k] = bus.in_amt;
                assign m_in[k] = bus.in_mode;
                assign s_in[k] = bus.in_data[WIDTH-1];
                assign c_in[k] = 1'b0;
            end else begin : g_body
                assign d_in[k] = d_q[k-1];
                assign a_in[k] = a_q[k-1];
                assign m_in[k] = m_q[k-1];
                assign s_in[k] = s_q[k-1];
                assign c_in[k] = c_q[k-1];
            end

            shift_pipe_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
                .d    (d_in[k]),
                .en   (a_in[k][k]),
                .mode (m_in[k]),
                .sign (s_in[k]),
                .cin  (c_in[k]),
                .q    (d_nx[k]),
                .cout (c_nx[k])
            );
        end
    endgenerate

    // Whole pipe moves or holds as one; bubbles are never squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            d_q      <= '0;
            c_q      <= '0;
            a_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            zero_q   <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[SHW-2:0], bus.in_valid};
            d_q      <= d_nx;
            c_q      <= c_nx;
            a_q      <= a_in[SHW-2:0];
            m_q      <= m_in[SHW-2:0];
            s_q      <= s_in[SHW-2:0];
            zero_q   <= (d_nx[SHW-1] == '0);
        end
    end

    assign bus.out_valid = vld_pipe[SHW-1];
    assign bus.out_data  = d_q[SHW-1];
    assign bus.out_zero  = zero_q;
    assign bus.out_carry = c_q[SHW-1];
endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: arithmetic reference model, in-order scoreboard with
// latency and stall-stability checks, directed vectors plus random traffic.
module tb_shift_pipe;
  localparam int W   = 16;
  localparam int SHW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(W)) bus();
  shift_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W+1:0] res;   // {data, zero, carry}
    int           acc_cyc;
    int           acc_st;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stalls = 0;
  bit          head_seen = 0;
  bit          prev_hold = 0;
  logic [W+2:0] hold_val;

  // Reference: whole-word arithmetic shift of the original operand.
  function automatic logic [W+1:0] model(logic [W-1:0] d, int a, logic [1:0] m);
    logic [W-1:0] r;
    logic         c;
    if (a == 0) begin
      r = d; c = 1'b0;
    end else begin
      case (m)
        2'd0: begin r = d << a; c = d[W-a]; end
        2'd1: begin r = W'($signed(d) >>> a); c = d[a-1]; end
        2'd2: begin r = d >> a; c = d[a-1]; end
        default: begin r = (d >> a) | (d << (W - a)); c = r[W-1]; end
      endcase
    end
    return {r, (r == '0), c};
  endfunction

  task automatic chk(string name, logic [W+2:0] act, logic [W+2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      head_seen = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold)
        chk("stall_stable", {bus.out_valid, bus.out_data, bus.out_zero, bus.out_carry}, hold_val);
      if (bus.out_valid && !head_seen) begin
        if (q.size() == 0) begin
          chk("spurious_result", {2'b0, bus.out_data, bus.out_valid}, '0);
        end else begin
          chk("latency", (W+3)'(cyc - q[0].acc_cyc - (stalls - q[0].acc_st)), (W+3)'(SHW));
        end
        head_seen = 1;
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        chk("result", {1'b0, bus.out_data, bus.out_zero, bus.out_carry}, {1'b0, q[0].res});
        void'(q.pop_front());
        head_seen = 0;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back('{model(bus.in_data, int'(bus.in_amt), bus.in_mode), cyc, stalls});
      prev_hold = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_valid, bus.out_data, bus.out_zero, bus.out_carry};
      if (!bus.in_ready) stalls++;
    end
    cyc++;
  end

  task automatic send(logic [W-1:0] d, int a, logic [1:0] m);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = SHW'(a);
    bus.in_mode  = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) return;
    end
    chk("drain_timeout", (W+3)'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;

    // Pin the reference model to hand-computed values.
    chk("m_sll12",  {1'b0, model(16'h0001, 12, 2'd0)}, {1'b0, 16'h1000, 1'b0, 1'b0});
    chk("m_sll15",  {1'b0, model(16'h0001, 15, 2'd0)}, {1'b0, 16'h8000, 1'b0, 1'b0});
    chk("m_sra15",  {1'b0, model(16'h8000, 15, 2'd1)}, {1'b0, 16'hFFFF, 1'b0, 1'b0});
    chk("m_sra4",   {1'b0, model(16'h7FF0,  4, 2'd1)}, {1'b0, 16'h07FF, 1'b0, 1'b0});
    chk("m_sra1",   {1'b0, model(16'h0003,  1, 2'd1)}, {1'b0, 16'h0001, 1'b0, 1'b1});
    chk("m_srl15",  {1'b0, model(16'h8000, 15, 2'd2)}, {1'b0, 16'h0001, 1'b0, 1'b0});
    chk("m_ror4",   {1'b0, model(16'h1234,  4, 2'd3)}, {1'b0, 16'h4123, 1'b0, 1'b0});
    chk("m_ror0",   {1'b0, model(16'h00F0,  0, 2'd3)}, {1'b0, 16'h00F0, 1'b0, 1'b0});
    chk("m_sll1z",  {1'b0, model(16'h8000,  1, 2'd0)}, {1'b0, 16'h0000, 1'b1, 1'b1});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out", {2'b0, bus.out_valid, bus.out_data, bus.out_zero, bus.out_carry}, '0);
    chk("reset_in_ready", {(W+2)'(0), bus.in_ready}, 1);
    @(posedge clk); #1;

    // Directed vectors, issued back-to-back.
    send(16'h0001, 12, 2'd0);
    send(16'h0001, 15, 2'd0);
    send(16'h8000, 15, 2'd1);
    send(16'h7FF0,  4, 2'd1);
    send(16'h0003,  1, 2'd1);
    send(16'h8000, 15, 2'd2);
    send(16'h1234,  4, 2'd3);
    for (int m = 0; m < 4; m++) send(16'h00F0, 0, 2'(m));
    send(16'h8000,  1, 2'd0);
    idle();
    drain();
    @(posedge clk); #1;

    // Back-pressure: 6 ops, then a 3-cycle hold once results emerge.
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'hA5C3 + i * 16'h1111), i + 3, 2'(i));
        idle();
      end
      begin
        for (int t = 0; t < 50 && !bus.out_valid; t++) @(negedge clk);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("hold_in_ready", {(W+2)'(0), bus.in_ready}, 0);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // Reset with three operations in flight.
    send(16'h1357, 3, 2'd0);
    send(16'h2468, 5, 2'd2);
    send(16'hFEDC, 7, 2'd3);
    idle();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", {(W+2)'(0), bus.out_valid}, 0);
    repeat (8) @(posedge clk);
    #1;
    send(16'h0F0F, 9, 2'd1);
    idle();
    drain();
    @(posedge clk); #1;

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = W'($urandom);
      bus.in_amt    = SHW'($urandom_range(0, W - 1));
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    idle();
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
